// File: rtl/timing_leak_monitor_if.sv
// ---------------------------------------------------------------------------
// timing_leak_monitor_if
//
// Bundles the monitor's run control, per-channel completion inputs and all
// measurement results into one interface.
//
//   master : drives start / chDone (test harness or DUT-copy wrapper),
//            observes every result.
//   slave  : the monitor itself; samples start / chDone, drives the results.
//
// Signals
//   start          run trigger shared with the monitored DUT copies
//   chDone         per-channel completion, bit i = copy i
//   busy           high while a run is being measured
//   timingLeak     last run showed differing latencies or a timeout
//   timingLeakDone one-cycle pulse marking fresh results
//   leakSticky     OR of timingLeak since reset
//   timeoutErr     last run ended without every channel completing
//   doneMask       channels that completed in the last/current run
//   latencyBus     per-channel latency, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//   spread         max - min latency over completed channels
// ---------------------------------------------------------------------------
interface timing_leak_monitor_if #(
    parameter int CHANNELS  = 2,
    parameter int CNT_WIDTH = 8
);
    logic                          start;
    logic [CHANNELS-1:0]           chDone;
    logic                          busy;
    logic                          timingLeak;
    logic                          timingLeakDone;
    logic                          leakSticky;
    logic                          timeoutErr;
    logic [CHANNELS-1:0]           doneMask;
    logic [CHANNELS*CNT_WIDTH-1:0] latencyBus;
    logic [CNT_WIDTH-1:0]          spread;

    modport master (
        output start, chDone,
        input  busy, timingLeak, timingLeakDone, leakSticky, timeoutErr,
               doneMask, latencyBus, spread
    );

    modport slave (
        input  start, chDone,
        output busy, timingLeak, timingLeakDone, leakSticky, timeoutErr,
               doneMask, latencyBus, spread
    );
endinterface

// File: rtl/timing_leak_monitor.sv
// ---------------------------------------------------------------------------
// timing_leak_monitor
//
// Measures the completion latency of CHANNELS identical DUT copies that are
// launched by one shared start pulse. Each run captures every channel's
// first completion cycle, then reports the max-min spread, a timeout flag
// and a leak flag (spread != 0 or timeout), plus a sticky leak flag that
// accumulates across runs until reset.
//
// Ports
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high; clears state, results and sticky flag
//   mon  : timing_leak_monitor_if.slave, run control in / results out
//
// Parameters
//   CHANNELS  : number of monitored copies (>= 2)
//   CNT_WIDTH : width of the cycle counter and of each latency field
//   TIMEOUT   : longest run in cycles, 1 <= TIMEOUT <= 2^CNT_WIDTH-1
// ---------------------------------------------------------------------------
module timing_leak_monitor #(
    parameter int CHANNELS  = 2,
    parameter int CNT_WIDTH = 8,
    parameter int TIMEOUT   = 200
) (
    input  logic                  clk,
    input  logic                  rst,
    timing_leak_monitor_if.slave  mon
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;

    logic [CNT_WIDTH-1:0]          r_cnt;
    logic [CHANNELS-1:0]           r_done_mask;
    logic [CNT_WIDTH-1:0]          r_lat [CHANNELS];
    logic [CNT_WIDTH-1:0]          r_spread;
    logic                          r_timeout_err;
    logic                          r_leak;
    logic                          r_sticky;
    logic                          r_busy;
    logic                          r_leak_done;

    logic [CHANNELS-1:0]           w_capture;
    logic [CHANNELS-1:0]           w_mask_nxt;
    logic [CNT_WIDTH-1:0]          w_lat_nxt [CHANNELS];
    logic                          w_all_done;
    logic                          w_cnt_at_limit;
    logic [CNT_WIDTH-1:0]          w_lat_max;
    logic [CNT_WIDTH-1:0]          w_lat_min;
    logic [CNT_WIDTH-1:0]          w_spread_nxt;
    logic                          w_leak_nxt;
    logic [CHANNELS*CNT_WIDTH-1:0] w_lat_bus;

    // Capture only the first completion per channel, and only while running.
    // The report decision looks at the mask/latencies including this cycle's
    // captures so that the last channel finishing ends the run immediately.
    always_comb begin
        w_capture  = '0;
        if (r_state == RUN) begin
            w_capture = mon.chDone & ~r_done_mask;
        end
        w_mask_nxt = r_done_mask | w_capture;
        for (int i = 0; i < CHANNELS; i++) begin
            w_lat_nxt[i] = w_capture[i] ? r_cnt : r_lat[i];
        end
        w_all_done     = &w_mask_nxt;
        w_cnt_at_limit = (r_cnt == CNT_WIDTH'(TIMEOUT));
    end

    // Min/max over completed channels only. With no completed channel the
    // min stays at all-ones, so the spread is forced to zero explicitly;
    // with exactly one it is naturally zero.
    always_comb begin
        w_lat_max = '0;
        w_lat_min = '1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_mask_nxt[i]) begin
                if (w_lat_nxt[i] > w_lat_max) begin
                    w_lat_max = w_lat_nxt[i];
                end
                if (w_lat_nxt[i] < w_lat_min) begin
                    w_lat_min = w_lat_nxt[i];
                end
            end
        end
        w_spread_nxt = '0;
        if (|w_mask_nxt) begin
            w_spread_nxt = w_lat_max - w_lat_min;
        end
        w_leak_nxt = (w_spread_nxt != '0) | ~w_all_done;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (mon.start) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_all_done || w_cnt_at_limit) begin
                    w_state_nxt = REPORT;
                end
            end
            REPORT: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_done_mask   <= '0;
            r_spread      <= '0;
            r_timeout_err <= 1'b0;
            r_leak        <= 1'b0;
            r_sticky      <= 1'b0;
            r_busy        <= 1'b0;
            r_leak_done   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_lat[i] <= '0;
            end
        end else begin
            // busy/done are registered copies of the state being entered.
            r_busy      <= (w_state_nxt == RUN);
            r_leak_done <= (w_state_nxt == REPORT);
            case (r_state)
                IDLE: begin
                    if (mon.start) begin
                        r_cnt       <= CNT_WIDTH'(1);
                        r_done_mask <= '0;
                        for (int i = 0; i < CHANNELS; i++) begin
                            r_lat[i] <= '0;
                        end
                    end
                end
                RUN: begin
                    r_done_mask <= w_mask_nxt;
                    for (int i = 0; i < CHANNELS; i++) begin
                        r_lat[i] <= w_lat_nxt[i];
                    end
                    if (w_state_nxt == REPORT) begin
                        r_spread      <= w_spread_nxt;
                        r_timeout_err <= ~w_all_done;
                        r_leak        <= w_leak_nxt;
                        r_sticky      <= r_sticky | w_leak_nxt;
                    end else begin
                        // Cannot wrap: the run ends when cnt reaches TIMEOUT.
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_lat_bus = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_lat_bus[i*CNT_WIDTH +: CNT_WIDTH] = r_lat[i];
        end
    end

    assign mon.busy           = r_busy;
    assign mon.timingLeak     = r_leak;
    assign mon.timingLeakDone = r_leak_done;
    assign mon.leakSticky     = r_sticky;
    assign mon.timeoutErr     = r_timeout_err;
    assign mon.doneMask       = r_done_mask;
    assign mon.latencyBus     = w_lat_bus;
    assign mon.spread         = r_spread;

endmodule

// File: tb/tb_timing_leak_monitor.sv
module tb_timing_leak_monitor;

    localparam int TMO = 20;

    typedef struct packed {
        logic [31:0] lat;
        logic [3:0]  mask;
        logic [7:0]  spread;
        logic        leak;
        logic        tmo;
        logic        sticky;
        int          endk;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       b_start;
    logic [3:0] b_done;
    int         sel;

    timing_leak_monitor_if #(.CHANNELS(2), .CNT_WIDTH(8)) if2 ();
    timing_leak_monitor_if #(.CHANNELS(4), .CNT_WIDTH(8)) if4 ();

    timing_leak_monitor #(.CHANNELS(2), .CNT_WIDTH(8), .TIMEOUT(TMO)) dut2 (
        .clk (clk),
        .rst (rst),
        .mon (if2.slave)
    );

    timing_leak_monitor #(.CHANNELS(4), .CNT_WIDTH(8), .TIMEOUT(TMO)) dut4 (
        .clk (clk),
        .rst (rst),
        .mon (if4.slave)
    );

    assign if2.start  = b_start & (sel == 0);
    assign if2.chDone = (sel == 0) ? b_done[1:0] : 2'b00;
    assign if4.start  = b_start & (sel == 1);
    assign if4.chDone = (sel == 1) ? b_done : 4'b0000;

    logic        o_busy, o_done, o_leak, o_sticky, o_tmo;
    logic [3:0]  o_mask;
    logic [7:0]  o_spread;
    logic [31:0] o_lat;

    assign o_busy   = (sel == 0) ? if2.busy           : if4.busy;
    assign o_done   = (sel == 0) ? if2.timingLeakDone : if4.timingLeakDone;
    assign o_leak   = (sel == 0) ? if2.timingLeak     : if4.timingLeak;
    assign o_sticky = (sel == 0) ? if2.leakSticky     : if4.leakSticky;
    assign o_tmo    = (sel == 0) ? if2.timeoutErr     : if4.timeoutErr;
    assign o_mask   = (sel == 0) ? {2'b00, if2.doneMask}    : if4.doneMask;
    assign o_spread = (sel == 0) ? if2.spread               : if4.spread;
    assign o_lat    = (sel == 0) ? {16'h0, if2.latencyBus}  : if4.latencyBus;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    bit   sticky_m [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a run ends at the latest completion if every channel
    // completes within TIMEOUT, otherwise after TIMEOUT cycles.
    function automatic exp_t model(input int n, input int d[4], input bit st_in);
        exp_t e;
        bit   all;
        int   mx, mn;
        e   = '0;
        all = 1'b1;
        mx  = 0;
        mn  = 1 << 30;
        for (int i = 0; i < n; i++) begin
            if (d[i] == 0 || d[i] > TMO) all = 1'b0;
        end
        if (all) begin
            e.endk = 0;
            for (int i = 0; i < n; i++) if (d[i] > e.endk) e.endk = d[i];
        end else begin
            e.endk = TMO;
        end
        for (int i = 0; i < n; i++) begin
            if (d[i] != 0 && d[i] <= e.endk) begin
                e.lat[i*8 +: 8] = d[i][7:0];
                e.mask[i]       = 1'b1;
                if (d[i] > mx) mx = d[i];
                if (d[i] < mn) mn = d[i];
            end
        end
        e.spread = (e.mask != 4'b0) ? 8'(mx - mn) : 8'd0;
        e.tmo    = !all;
        e.leak   = (e.spread != 8'd0) || e.tmo;
        e.sticky = st_in | e.leak;
        return e;
    endfunction

    // d*: completion cycle per channel (0 = never), h*: cycles held high.
    // poke asserts start in RUN cycle 2 and during REPORT; both must be ignored.
    task automatic run(input int s, input int d0, input int d1, input int d2, input int d3,
                       input int h0, input int h1, input int h2, input int h3, input bit poke);
        int   d[4];
        int   h[4];
        int   n;
        int   k;
        bit   got;
        exp_t e;
        exp_t g;
        sel = s;
        n   = (s == 0) ? 2 : 4;
        d   = '{d0, d1, d2, d3};
        h   = '{h0, h1, h2, h3};
        e   = model(n, d, sticky_m[s]);
        sticky_m[s] = e.sticky;
        sb.push_back(e);

        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        k   = 1;
        got = 1'b0;
        while (!got && k <= TMO + 5) begin
            b_done = 4'b0;
            for (int i = 0; i < n; i++) begin
                if (d[i] != 0 && k >= d[i] && k < d[i] + h[i]) b_done[i] = 1'b1;
            end
            b_start = poke && (k == 2);
            if (k == 1) chk("busy_in_run", 32'(o_busy), 32'd1);
            tick();
            if (o_done) got = 1'b1;
            else k++;
        end
        b_done  = 4'b0;
        b_start = poke;

        chk("report_seen", 32'(got), 32'd1);
        g = sb.pop_front();
        chk("report_cycle", 32'(k), 32'(g.endk));
        chk("latencyBus", o_lat, g.lat);
        chk("doneMask", 32'(o_mask), 32'(g.mask));
        chk("spread", 32'(o_spread), 32'(g.spread));
        chk("timingLeak", 32'(o_leak), 32'(g.leak));
        chk("timeoutErr", 32'(o_tmo), 32'(g.tmo));
        chk("leakSticky", 32'(o_sticky), 32'(g.sticky));
        chk("busy_in_report", 32'(o_busy), 32'd0);

        tick();
        b_start = 1'b0;
        chk("done_single_pulse", 32'(o_done), 32'd0);
        chk("report_start_ignored", 32'(o_busy), 32'd0);
        chk("latency_hold", o_lat, g.lat);
        chk("leak_hold", 32'(o_leak), 32'(g.leak));
    endtask

    task automatic check_zero(input int s, input string tag);
        sel = s;
        #0;
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_done"}, 32'(o_done), 32'd0);
        chk({tag, "_leak"}, 32'(o_leak), 32'd0);
        chk({tag, "_sticky"}, 32'(o_sticky), 32'd0);
        chk({tag, "_tmo"}, 32'(o_tmo), 32'd0);
        chk({tag, "_mask"}, 32'(o_mask), 32'd0);
        chk({tag, "_spread"}, 32'(o_spread), 32'd0);
        chk({tag, "_lat"}, o_lat, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        b_start = 1'b0;
        b_done  = 4'b0;
        sel     = 0;
        sticky_m[0] = 1'b0;
        sticky_m[1] = 1'b0;
        tick();
        tick();
        check_zero(0, "reset2");
        check_zero(1, "reset4");
        rst = 1'b0;
        tick();

        // Equal latency, then skew, then a clean run with ignored starts.
        run(0, 5, 5, 0, 0, 1, 1, 0, 0, 1'b0);
        run(0, 5, 7, 0, 0, 1, 1, 0, 0, 1'b0);
        run(0, 5, 5, 0, 0, 1, 1, 0, 0, 1'b1);

        // chDone while idle must not touch the held results.
        sel    = 0;
        b_done = 4'b0011;
        tick();
        tick();
        b_done = 4'b0;
        chk("idle_chdone_mask", 32'(o_mask), 32'h3);
        chk("idle_chdone_lat", o_lat, 32'h0505);
        chk("idle_chdone_busy", 32'(o_busy), 32'd0);
        chk("idle_chdone_done", 32'(o_done), 32'd0);

        // Timeout with ch1 never completing.
        run(0, 4, 0, 0, 0, 1, 0, 0, 0, 1'b0);

        // Reset in RUN cycle 3, then a fresh measurement.
        sel     = 0;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sticky_m[0] = 1'b0;
        sticky_m[1] = 1'b0;
        check_zero(0, "midrun_reset");
        run(0, 3, 3, 0, 0, 1, 1, 0, 0, 1'b0);

        // Four channels: late ch3 held high, then an early ch0 held high.
        run(1, 9, 9, 9, 12, 1, 1, 1, 3, 1'b0);
        run(1, 2, 8, 8, 8, 5, 1, 1, 1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timing_leak_monitor.md
# timing_leak_monitor

Parametrised N-channel timing-leak monitor for constant-time datapath testing. Replaces the fixed two-copy pass/fail comparison with per-channel latency measurement. For every run it captures each channel's completion cycle, the spread between fastest and slowest channel, a timeout error and a sticky leak flag. It sits beside CHANNELS identical DUT copies (e.g. `Multiplier_ConstantTime`) driven from a shared `start`, consuming their `productDone` signals.

## Interface
- `CHANNELS`, default 2: number of monitored DUT copies; at least 2.
- `CNT_WIDTH`, default 8: width of the cycle counter and each latency field.
- `TIMEOUT`, default 200: maximum run length in cycles; must satisfy 1 ≤ TIMEOUT ≤ 2^CNT_WIDTH−1.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a run; same pulse the DUT copies receive.
- `chDone`  in  CHANNELS  per-channel completion (`productDone` of copy i on bit i).
- `busy`  out  1  high while in RUN.
- `timingLeak`  out  1  result of last run: 1 if the channel latencies differ or a timeout occurred.
- `timingLeakDone`  out  1  one-cycle pulse; the result outputs are valid from this cycle on.
- `leakSticky`  out  1  OR of `timingLeak` over all runs since reset.
- `timeoutErr`  out  1  last run ended by timeout.
- `doneMask`  out  CHANNELS  channels that completed in the last or current run.
- `latencyBus`  out  CHANNELS*CNT_WIDTH  captured latency of channel i in bits [i*CNT_WIDTH +: CNT_WIDTH]; 0 if the channel did not complete.
- `spread`  out  CNT_WIDTH  max − min latency over completed channels; 0 if fewer than 2 channels completed.

## Operation
- FSM states: IDLE, RUN, REPORT.
- **IDLE**
  - `start`=1 → RUN.
  - On the same edge: `cnt` ← 1, `doneMask` ← 0, all latencies ← 0.
  - `chDone` is ignored in IDLE.
- **RUN**
  - Each cycle, for every channel i with `chDone[i]`=1 and `doneMask[i]`=0: latency_i ← `cnt`, `doneMask[i]` ← 1.
  - Only the first assertion per channel is captured; a held or repeated `chDone` is ignored.
  - `start` is ignored in RUN.
  - All channels done, counting captures made this cycle → REPORT.
  - Else if `cnt` == TIMEOUT → REPORT with timeout flagged.
  - Else `cnt` ← `cnt`+1.
- **REPORT** (one cycle), then → IDLE. On entry into REPORT, registered:
  - `spread` = max − min over completed channels.
  - `timeoutErr` = not all channels completed.
  - `timingLeak` = (`spread` ≠ 0) | `timeoutErr`.
  - `leakSticky` |= `timingLeak`.
- `timingLeakDone` = 1 only while in REPORT.
- `timingLeak`, `spread`, `timeoutErr`, `latencyBus` and `doneMask` hold until the next accepted `start`. On that start, `latencyBus` and `doneMask` clear; `timingLeak`, `spread` and `timeoutErr` hold until the next REPORT.
- Arithmetic is unsigned. `cnt` never exceeds TIMEOUT, so it never wraps.
- Min/max is a combinational reduction over CHANNELS, masked by `doneMask`.
- `rst`=1 overrides everything, including mid-run: state → IDLE and all outputs, counters and `leakSticky` → 0 on the next edge.

## Timing
- Reset value of every output is 0.
- Start accepted at edge E; the first RUN cycle follows E with `cnt`=1.
- A `chDone` sampled in the k-th RUN cycle records latency k.
- When the last channel completes in RUN cycle k, REPORT is the next cycle and `timingLeakDone` pulses at cycle k+1 after E.
- On timeout, RUN lasts exactly TIMEOUT cycles and REPORT follows.
- A `start` asserted during REPORT is ignored. The earliest accepted restart is the first IDLE cycle, which is two cycles after the last RUN cycle.
- `busy` is registered and equals (state == RUN).

## Test plan
- **Equal latency.** CHANNELS=2, `start`, both `chDone` at `cnt`=5 → `latencyBus`={5,5}, `spread`=0, `timingLeak`=0, `timingLeakDone` one pulse at cycle 6 after accept, `doneMask`=11.
- **Skewed latency, then clean run.** ch0 done at 5, ch1 at 7 → `spread`=2, `timingLeak`=1, `leakSticky`=1. Next equal run → `timingLeak`=0, `leakSticky` stays 1.
- **Timeout.** TIMEOUT=20, ch1 never done, ch0 at 4 → REPORT after 20 RUN cycles, `timeoutErr`=1, `timingLeak`=1, `doneMask`=01, ch1 latency 0, `spread`=0.
- **Multi-channel.** CHANNELS=4, dones at 9,9,9,12 with ch3 held high 3 cycles → ch3 latency 12, `spread`=3, `timingLeak`=1.
- **Reset mid-run.** `rst` at `cnt`=3 → next cycle all outputs 0, state IDLE. A fresh `start` then measures normally.
- **Ignored inputs.** `chDone` pulses in IDLE, and `start` asserted in RUN and in REPORT → no effect on `cnt`, latencies or state.
